pagerank_edge_scatter: RTL and testbench

//  Upstream (DMP/scatter) stage of the PageRank pipeline; feeds the per-iteration rank accumulator.
//  Per iteration: latches current ranks and out-degrees, computes contrib[i] = rank[i]/out_degree[i].

---
 rtl/pagerank_pkg.sv | 22 ++
 rtl/fxp_serial_divider.sv | 57 +++++
 rtl/pagerank_edge_scatter.sv | 176 +++++++++++++++++
 tb/tb_pagerank_edge_scatter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pagerank_pkg.sv
// Shared types for the PageRank scatter stage: Q32.32 rank type, scatter FSM states, index helper.
package pagerank_pkg;

  typedef logic [63:0] rank_t;

  localparam int FRAC_BITS = 32;
  localparam int MAX_ITER  = 500;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_DIVIDE,
    S_SCATTER,
    S_FLUSH,
    S_DONE
  } scatter_state_t;

  function automatic logic idx_in_range(input logic [31:0] idx, input int unsigned n);
    return idx < n;
  endfunction

endpackage

// File: rtl/fxp_serial_divider.sv
// Restoring serial divider: 64-bit dividend / 32-bit divisor, one quotient bit per cycle.
// The first bit is resolved on the start cycle, so done pulses 64 cycles after start.
module fxp_serial_divider (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [63:0] quotient
);

  logic [31:0] rem;
  logic [5:0]  steps_left;
  logic [31:0] src_rem;
  logic [63:0] src_q;
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] next_rem;

  // A divisor of zero always passes the trial subtraction, giving an all-ones quotient.
  always_comb begin
    src_rem  = start ? 32'd0 : rem;
    src_q    = start ? dividend : quotient;
    shifted  = {src_rem, src_q[63]};
    ge       = (shifted >= {1'b0, divisor});
    next_rem = ge ? (shifted[31:0] - divisor) : shifted[31:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rem        <= '0;
      quotient   <= '0;
      steps_left <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem        <= next_rem;
        quotient   <= {src_q[62:0], ge};
        steps_left <= 6'd63;
        busy       <= 1'b1;
      end else if (busy) begin
        rem        <= next_rem;
        quotient   <= {src_q[62:0], ge};
        steps_left <= steps_left - 6'd1;
        if (steps_left == 6'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pagerank_edge_scatter.sv
// PageRank scatter stage: per-node rank/out_degree contribution, then one lane-vector beat per edge.
// Optional PAGERANK_DANGLING_REDIST_EN adds a final beat spreading dangling-node rank over all lanes.
//
// state   | meaning
// IDLE    | waiting for iter_start
// LATCH   | capture ranks and degrees, clear idx_err
// DIVIDE  | compute contrib[ptr], one node at a time
// SCATTER | accept edges, emit one beat per edge
// FLUSH   | dangling-rank beat (PAGERANK_DANGLING_REDIST_EN only)
// DONE    | raise stream_done for the following cycle
module pagerank_edge_scatter
  import pagerank_pkg::*;
#(
  parameter  int NODES_IN_GRAPH = 32,
  localparam int IDX_W          = $clog2(NODES_IN_GRAPH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iter_start,
  input  rank_t             rank_in [NODES_IN_GRAPH],
  input  logic [31:0]       out_degree [NODES_IN_GRAPH],
  input  logic              edge_valid,
  output logic              edge_ready,
  input  logic [IDX_W-1:0]  edge_src,
  input  logic [IDX_W-1:0]  edge_dst,
  input  logic              edge_last,
  output rank_t             pagerank_serial_stream [NODES_IN_GRAPH],
  output logic              stream_valid,
  output logic              stream_start,
  output logic              stream_done,
  output logic              busy,
  output logic              idx_err
);

  localparam logic [IDX_W-1:0] LAST_NODE = IDX_W'(NODES_IN_GRAPH - 1);

  scatter_state_t   state;
  rank_t            rank_q  [NODES_IN_GRAPH];
  logic [31:0]      deg_q   [NODES_IN_GRAPH];
  rank_t            contrib [NODES_IN_GRAPH];
  logic [IDX_W-1:0] ptr;
  logic             div_wait;
  logic             first_beat;
  logic             div_start;
  logic             div_busy;
  logic             div_done;
  rank_t            div_dividend;
  logic [31:0]      div_divisor;
  rank_t            div_quotient;
  logic             node_done;
  logic             idx_ok;
`ifdef PAGERANK_DANGLING_REDIST_EN
  rank_t            dsum;
`endif

  assign edge_ready = (state == S_SCATTER);
  assign busy       = (state != S_IDLE);
  assign idx_ok     = idx_in_range(32'(edge_src), NODES_IN_GRAPH) &&
                      idx_in_range(32'(edge_dst), NODES_IN_GRAPH);
  assign node_done  = (state == S_DIVIDE) && (div_wait ? div_done : (deg_q[ptr] == '0));

  always_comb begin
    div_dividend = rank_q[ptr];
    div_divisor  = deg_q[ptr];
    div_start    = (state == S_DIVIDE) && !div_wait && !div_busy && (deg_q[ptr] != '0);
`ifdef PAGERANK_DANGLING_REDIST_EN
    if (state == S_FLUSH) begin
      div_dividend = dsum;
      div_divisor  = 32'(NODES_IN_GRAPH);
      div_start    = !div_wait && !div_busy;
    end
`endif
  end

  fxp_serial_divider u_div (
    .clock    (clock),
    .reset    (reset),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      ptr          <= '0;
      div_wait     <= 1'b0;
      first_beat   <= 1'b0;
      stream_valid <= 1'b0;
      stream_start <= 1'b0;
      stream_done  <= 1'b0;
      idx_err      <= 1'b0;
      for (int i = 0; i < NODES_IN_GRAPH; i++) begin
        rank_q[i]                 <= '0;
        deg_q[i]                  <= '0;
        contrib[i]                <= '0;
        pagerank_serial_stream[i] <= '0;
      end
`ifdef PAGERANK_DANGLING_REDIST_EN
      dsum <= '0;
`endif
    end else begin
      stream_valid <= 1'b0;
      stream_start <= 1'b0;
      stream_done  <= 1'b0;
      case (state)
        S_IDLE: if (iter_start) state <= S_LATCH;
        S_LATCH: begin
          for (int i = 0; i < NODES_IN_GRAPH; i++) begin
            rank_q[i] <= rank_in[i];
            deg_q[i]  <= out_degree[i];
          end
          ptr        <= '0;
          idx_err    <= 1'b0;
          first_beat <= 1'b1;
          div_wait   <= 1'b0;
`ifdef PAGERANK_DANGLING_REDIST_EN
          dsum <= '0;
`endif
          state <= S_DIVIDE;
        end
        S_DIVIDE: begin
          if (div_start) div_wait <= 1'b1;
          if (node_done) begin
            contrib[ptr] <= div_wait ? div_quotient : '0;
            div_wait     <= 1'b0;
`ifdef PAGERANK_DANGLING_REDIST_EN
            if (!div_wait) dsum <= dsum + rank_q[ptr];
`endif
            if (ptr == LAST_NODE) state <= S_SCATTER;
            else                  ptr   <= ptr + IDX_W'(1);
          end
        end
        S_SCATTER: begin
          if (edge_valid) begin
            stream_valid <= 1'b1;
            stream_start <= first_beat;
            first_beat   <= 1'b0;
            // Out-of-range endpoints still produce a beat, but it carries no rank.
            for (int l = 0; l < NODES_IN_GRAPH; l++)
              pagerank_serial_stream[l] <= (idx_ok && l == int'(edge_dst)) ? contrib[edge_src] : '0;
            if (!idx_ok) idx_err <= 1'b1;
`ifdef PAGERANK_DANGLING_REDIST_EN
            if (edge_last) state <= S_FLUSH;
`else
            if (edge_last) state <= S_DONE;
`endif
          end
        end
`ifdef PAGERANK_DANGLING_REDIST_EN
        S_FLUSH: begin
          if (div_start) div_wait <= 1'b1;
          if (div_wait && div_done) begin
            for (int l = 0; l < NODES_IN_GRAPH; l++)
              pagerank_serial_stream[l] <= div_quotient;
            stream_valid <= 1'b1;
            stream_start <= first_beat;
            first_beat   <= 1'b0;
            div_wait     <= 1'b0;
            state        <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          stream_done <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pagerank_edge_scatter.sv
// Directed bench for pagerank_edge_scatter: a 4-node instance for the main flow and a 6-node one for index errors.
module tb_pagerank_edge_scatter;
  import pagerank_pkg::*;

  localparam rank_t Q25 = 64'h0000_0000_4000_0000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        iter_start, edge_valid, edge_last;
  logic [1:0]  edge_src, edge_dst;
  rank_t       rank_in [4];
  logic [31:0] out_degree [4];
  rank_t       lanes [4];
  logic        edge_ready, stream_valid, stream_start, stream_done, busy, idx_err;

  logic        iter6, ev6, last6;
  logic [2:0]  src6, dst6;
  rank_t       rank6 [6];
  logic [31:0] deg6 [6];
  rank_t       lanes6 [6];
  logic        ready6, valid6, start6, done6, busy6, err6;

  int checks = 0;
  int errors = 0;

  pagerank_edge_scatter #(.NODES_IN_GRAPH(4)) u4 (
    .clock(clock), .reset(reset), .iter_start(iter_start),
    .rank_in(rank_in), .out_degree(out_degree),
    .edge_valid(edge_valid), .edge_ready(edge_ready),
    .edge_src(edge_src), .edge_dst(edge_dst), .edge_last(edge_last),
    .pagerank_serial_stream(lanes), .stream_valid(stream_valid),
    .stream_start(stream_start), .stream_done(stream_done),
    .busy(busy), .idx_err(idx_err)
  );

  pagerank_edge_scatter #(.NODES_IN_GRAPH(6)) u6 (
    .clock(clock), .reset(reset), .iter_start(iter6),
    .rank_in(rank6), .out_degree(deg6),
    .edge_valid(ev6), .edge_ready(ready6),
    .edge_src(src6), .edge_dst(dst6), .edge_last(last6),
    .pagerank_serial_stream(lanes6), .stream_valid(valid6),
    .stream_start(start6), .stream_done(done6),
    .busy(busy6), .idx_err(err6)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_cfg(input rank_t r0, input rank_t r1, input rank_t r2, input rank_t r3,
                         input int d0, input int d1, input int d2, input int d3);
    rank_in[0] = r0; rank_in[1] = r1; rank_in[2] = r2; rank_in[3] = r3;
    out_degree[0] = 32'(d0); out_degree[1] = 32'(d1);
    out_degree[2] = 32'(d2); out_degree[3] = 32'(d3);
  endtask

  task automatic start_iter();
    iter_start = 1'b1;
    tick();
    iter_start = 1'b0;
  endtask

  // Counts cycles from the iter_start edge until edge_ready rises.
  task automatic wait_ready(input string tag, input int exp);
    int n = 1;
    while (!edge_ready && n < 2000) begin
      tick();
      n++;
    end
    check(tag, 64'(n), 64'(exp));
  endtask

  task automatic send_edge(input logic [1:0] s, input logic [1:0] d, input logic l);
    edge_src = s; edge_dst = d; edge_last = l; edge_valid = 1'b1;
    tick();
    edge_valid = 1'b0;
    edge_last  = 1'b0;
  endtask

  task automatic check_beat(input string tag, input int dst, input rank_t val, input logic first);
    check({tag, "_valid"}, 64'(stream_valid), 64'd1);
    check({tag, "_start"}, 64'(stream_start), 64'(first));
    for (int l = 0; l < 4; l++)
      check($sformatf("%s_lane%0d", tag, l), lanes[l], (l == dst) ? val : 64'd0);
  endtask

  // Entered in the cycle the last scatter beat is visible.
  task automatic end_iter(input string tag, input rank_t fv);
    check({tag, "_done_early"}, 64'(stream_done), 64'd0);
`ifdef PAGERANK_DANGLING_REDIST_EN
    begin
      int n = 0;
      tick();
      while (!stream_valid && n < 200) begin
        tick();
        n++;
      end
      check({tag, "_flush_valid"}, 64'(stream_valid), 64'd1);
      check({tag, "_flush_start"}, 64'(stream_start), 64'd0);
      for (int l = 0; l < 4; l++)
        check($sformatf("%s_flush_lane%0d", tag, l), lanes[l], fv);
    end
`endif
    tick();
    check({tag, "_done"}, 64'(stream_done), 64'd1);
    check({tag, "_done_novalid"}, 64'(stream_valid), 64'd0);
    check({tag, "_done_idle"}, 64'(busy), 64'd0);
    tick();
    check({tag, "_done_pulse"}, 64'(stream_done), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    iter_start = 0; edge_valid = 0; edge_last = 0; edge_src = 0; edge_dst = 0;
    iter6 = 0; ev6 = 0; last6 = 0; src6 = 0; dst6 = 0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      rank6[i] = '0;
      deg6[i]  = '0;
    end
    reset = 1'b1;
    tick();
    tick();

    check("rst_busy", 64'(busy), 0);
    check("rst_ready", 64'(edge_ready), 0);
    check("rst_valid", 64'(stream_valid), 0);
    check("rst_start", 64'(stream_start), 0);
    check("rst_done", 64'(stream_done), 0);
    check("rst_idx_err", 64'(idx_err), 0);
    check("rst_lane1", lanes[1], 0);
    check("rst_busy6", 64'(busy6), 0);
    reset = 1'b0;
    tick();

    // 1: uniform ranks, degree 1, ring of edges
    set_cfg(Q25, Q25, Q25, Q25, 1, 1, 1, 1);
    start_iter();
    wait_ready("t1_latency", 262);
    send_edge(0, 1, 0); check_beat("t1_b1", 1, Q25, 1);
    send_edge(1, 2, 0); check_beat("t1_b2", 2, Q25, 0);
    send_edge(2, 3, 0); check_beat("t1_b3", 3, Q25, 0);
    send_edge(3, 0, 1); check_beat("t1_b4", 0, Q25, 0);
    end_iter("t1", 0);

    // 2: 1.0 / 3 truncates; one 65-cycle divide plus three 1-cycle zero-degree nodes
    set_cfg(64'h1_0000_0000, 0, 0, 0, 3, 0, 0, 0);
    start_iter();
    wait_ready("t2_latency", 70);
    send_edge(0, 1, 0); check_beat("t2_b1", 1, 64'h5555_5555, 1);
    send_edge(0, 2, 0); check_beat("t2_b2", 2, 64'h5555_5555, 0);
    send_edge(0, 3, 1); check_beat("t2_b3", 3, 64'h5555_5555, 0);
    end_iter("t2", 0);

    // 3: dangling node 2 contributes nothing to the edge beats
    set_cfg(Q25, Q25, 64'h8000_0000, Q25, 1, 1, 0, 1);
    start_iter();
    wait_ready("t3_latency", 198);
    send_edge(2, 0, 0); check_beat("t3_b1", 0, 0, 1);
    send_edge(1, 3, 1); check_beat("t3_b2", 3, Q25, 0);
    end_iter("t3", 64'h2000_0000);

    // 4: gap in edge_valid, and an iter_start during SCATTER that must be ignored
    set_cfg(Q25, Q25, Q25, Q25, 1, 1, 1, 1);
    start_iter();
    wait_ready("t4_latency", 262);
    send_edge(0, 1, 0); check_beat("t4_b1", 1, Q25, 1);
    iter_start = 1'b1;
    tick();
    iter_start = 1'b0;
    check("t4_gap_valid", 64'(stream_valid), 0);
    check("t4_gap_ready", 64'(edge_ready), 1);
    check("t4_gap_busy", 64'(busy), 1);
    send_edge(2, 3, 1); check_beat("t4_b2", 3, Q25, 0);
    end_iter("t4", 0);

    // 5: out-of-range source on the 6-node instance
    rank6[0] = Q25;
    deg6[0]  = 32'd1;
    iter6 = 1'b1;
    tick();
    iter6 = 1'b0;
    begin
      int n = 1;
      while (!ready6 && n < 2000) begin
        tick();
        n++;
      end
      check("t5_latency", 64'(n), 72);
    end
    src6 = 3'd7; dst6 = 3'd1; last6 = 1'b0; ev6 = 1'b1;
    tick();
    check("t5_bad_valid", 64'(valid6), 1);
    check("t5_bad_err", 64'(err6), 1);
    for (int l = 0; l < 6; l++)
      check($sformatf("t5_bad_lane%0d", l), lanes6[l], 0);
    src6 = 3'd0; dst6 = 3'd2; last6 = 1'b1;
    tick();
    ev6 = 1'b0;
    last6 = 1'b0;
    check("t5_good_lane2", lanes6[2], Q25);
    check("t5_good_lane1", lanes6[1], 0);
    check("t5_err_sticky", 64'(err6), 1);
    begin
      int n = 0;
      while (busy6 && n < 200) begin
        tick();
        n++;
      end
      check("t5_idle", 64'(busy6), 0);
    end
    check("t5_err_idle", 64'(err6), 1);
    iter6 = 1'b1;
    tick();
    iter6 = 1'b0;
    tick();
    check("t5_err_cleared", 64'(err6), 0);

    // 6: reset mid-DIVIDE, then mid-SCATTER, then a clean iteration
    set_cfg(Q25, Q25, Q25, Q25, 1, 1, 1, 1);
    start_iter();
    repeat (20) tick();
    reset = 1'b1;
    tick();
    check("t6_div_busy", 64'(busy), 0);
    check("t6_div_ready", 64'(edge_ready), 0);
    check("t6_div_done", 64'(stream_done), 0);
    check("t6_div_busy6", 64'(busy6), 0);
    reset = 1'b0;
    tick();
    start_iter();
    wait_ready("t6_latency", 262);
    send_edge(0, 1, 0);
    check("t6_sc_beat", 64'(stream_valid), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_sc_valid", 64'(stream_valid), 0);
    check("t6_sc_lane1", lanes[1], 0);
    check("t6_sc_busy", 64'(busy), 0);
    begin
      logic seen_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
        tick();
        seen_done |= stream_done;
      end
      check("t6_no_done", 64'(seen_done), 0);
    end
    start_iter();
    wait_ready("t6_clean_latency", 262);
    send_edge(3, 0, 1); check_beat("t6_clean_b1", 0, Q25, 1);
    end_iter("t6_clean", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
